ddram_responder: RTL and testbench
==================================

DDRAM_RESPONDER -- requirements
Module: ddram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12: backing-store address width, in 64-bit words.
REQ-002 SHALL have parameter BASE, default 7'b0011000: required value of DDRAM_ADDR[28:22].
REQ-003 SHALL have parameter RD_LAT, default 4: cycles from read-command accept to first data beat, range 1..15.
REQ-004 SHALL have parameter STALL_EN, default 0: 1 enables pseudo-random BUSY insertion.
REQ-005 SHALL have port clk, input, 1: sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port DDRAM_BUSY, output, 1: waitrequest; a command is accepted only when it is 0.
REQ-008 SHALL have port DDRAM_BURSTCNT, input, 8: burst length in beats, sampled on the first beat.
REQ-009 SHALL have port DDRAM_ADDR, input, 29: 64-bit word address, sampled on the first beat.
REQ-010 SHALL have port DDRAM_RD, input, 1: read command.
REQ-011 SHALL have port DDRAM_WE, input, 1: write beat.
REQ-012 SHALL have port DDRAM_DIN, input, 64: write data.
REQ-013 SHALL have port DDRAM_BE, input, 8: byte enables; bit 7 maps to data[63:56].
REQ-014 SHALL have port DDRAM_DOUT, output, 64: read data.
REQ-015 SHALL have port DDRAM_DOUT_READY, output, 1: read beat valid, one beat per cycle.
REQ-016 SHALL have port err_cnt, output, 8: saturating protocol/window error count.

Function
REQ-017 SHALL implement states IDLE, WBURST, RLAT, RBURST.
REQ-018 IDLE: accept WE (priority over RD) when BUSY=0, writing the beat at word ADDR[MEM_AW-1:0] under BE.
- If BURSTCNT>1: latch address+1 and remaining=BURSTCNT-1, then enter WBURST.
- Otherwise: stay in IDLE.
REQ-019 WBURST: each cycle with WE=1 and BUSY=0 SHALL write DIN/BE to the latched address, then increment address and decrement remaining.
- When remaining reaches 0: return to IDLE.
- RD=1 in WBURST: SHALL be ignored and increment err_cnt.
REQ-020 IDLE read accept (RD=1, WE=0, BUSY=0): latch address and count, then enter RLAT.
- After RD_LAT cycles, enter RBURST.
REQ-021 RBURST: SHALL assert DOUT_READY for exactly count consecutive cycles with mem[addr], mem[addr+1], ...; then return to IDLE.
REQ-022 BURSTCNT=0 SHALL be treated as 1.
REQ-023 Address increment SHALL wrap modulo 2^MEM_AW.
REQ-024 DDRAM_BUSY SHALL be 1 throughout RLAT and RBURST.
REQ-025 When STALL_EN=1, BUSY SHALL also be 1 in IDLE/WBURST whenever lfsr[1:0]==2'b00.
- lfsr: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advancing every cycle.
REQ-026 When STALL_EN=0, BUSY SHALL be 0 in IDLE/WBURST.
REQ-027 A command with ADDR[28:22]!=BASE SHALL increment err_cnt.
- Write beats SHALL be dropped.
- Reads SHALL return 64'hDEADBEEF_DEADBEEF per beat with normal timing.
REQ-028 err_cnt SHALL saturate at 8'hFF.
REQ-029 DOUT SHALL hold its last value when DOUT_READY=0.
REQ-030 A write followed by a read of the same word SHALL return the written data (read-after-write coherent).
REQ-031 Simultaneous RD and WE in IDLE SHALL perform the write only and increment err_cnt.

Reset
REQ-032 While rst=1: state=IDLE, DDRAM_BUSY=1, DOUT_READY=0, DOUT=0, err_cnt=0, lfsr=16'hACE1.
REQ-033 The cycle after rst falls: BUSY SHALL follow REQ-025/REQ-026.
REQ-034 Reset mid-burst SHALL abort the burst.
- Memory contents SHALL be retained.
- No DOUT_READY SHALL be asserted after reset until a new read is accepted.

Verification
REQ-035 STALL_EN=0. Write burst 1 at ADDR=0x18000010, DIN=0x0123456789ABCDEF, BE=0xFF; then read burst 1 at the same ADDR -> DOUT_READY one cycle, RD_LAT+1 cycles after accept, DOUT=0x0123456789ABCDEF.
REQ-036 Byte merge: write 0x1111111111111111 BE=0xFF, then 0x2222222222222222 BE=0xF0 at the same word; read -> 0x2222222211111111.
REQ-037 Read burst 4 at word 2^MEM_AW-2 after prefill with the values 0..N-1 -> beats return words N-2, N-1, 0, 1 on 4 consecutive cycles; BUSY=1 until the last beat.
REQ-038 ADDR=0x00000005 (window miss): write then read -> err_cnt=2, read beat=0xDEADBEEFDEADBEEF, mem[5] unchanged.
REQ-039 STALL_EN=1, 1000 random single writes followed by reads, master honouring BUSY -> all data matches, err_cnt=0.
REQ-040 Assert rst on the 2nd beat of a 4-beat read -> DOUT_READY=0 during and after reset; subsequent read of the same address returns the original data.

Source files
------------

// File: rtl/ddram_responder.sv
// Behavioural DDRAM slave: a 64-bit word store behind an address window, with
// burst writes, fixed-latency burst reads, optional LFSR waitrequest and an error counter.
module ddram_responder #(
    parameter int         MEM_AW   = 12,
    parameter logic [6:0] BASE     = 7'b0011000,
    parameter int         RD_LAT   = 4,
    parameter bit         STALL_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    input  logic        DDRAM_RD,
    input  logic        DDRAM_WE,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    output logic [7:0]  err_cnt,
    output logic [1:0]  state_dbg
);

    // Handshake: a command or write beat transfers on a rising edge where RD or WE
    // is high and BUSY is low; DOUT is valid on every cycle DOUT_READY is high.
    typedef enum logic [1:0] {IDLE, WBURST, RLAT, RBURST} state_t;

    state_t state, state_nxt;

    logic [63:0]       mem [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0] addr_q;
    logic [7:0]        cnt_q;
    logic [3:0]        lat_q;
    logic              miss_q;
    logic [15:0]       lfsr_q;
    logic [63:0]       dout_q;
    logic              ready_q;
    logic [7:0]        err_q;

    logic              stall, busy_int, open, hit;
    logic [7:0]        burst_len;
    logic              idle_wr, idle_rd, wb_wr, mem_we;
    logic [MEM_AW-1:0] mem_wa;
    logic              e_wmiss, e_rmiss, e_both, e_wbrd;
    logic [1:0]        err_inc;
    logic [8:0]        err_sum;
    logic              unused_addr;

    assign stall     = STALL_EN && (lfsr_q[1:0] == 2'b00);
    assign busy_int  = (state == RLAT) || (state == RBURST) || stall;
    assign open      = !busy_int;
    assign hit       = (DDRAM_ADDR[28:22] == BASE);
    assign burst_len = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

    // WE wins over RD when both arrive together in IDLE.
    assign idle_wr = (state == IDLE) && open && DDRAM_WE;
    assign idle_rd = (state == IDLE) && open && DDRAM_RD && !DDRAM_WE;
    assign wb_wr   = (state == WBURST) && open && DDRAM_WE;
    assign mem_we  = (idle_wr && hit) || (wb_wr && !miss_q);
    assign mem_wa  = idle_wr ? DDRAM_ADDR[MEM_AW-1:0] : addr_q;

    assign e_wmiss = idle_wr && !hit;
    assign e_rmiss = idle_rd && !hit;
    assign e_both  = (state == IDLE) && open && DDRAM_RD && DDRAM_WE;
    assign e_wbrd  = (state == WBURST) && open && DDRAM_RD;
    assign err_inc = {1'b0, e_wmiss} + {1'b0, e_rmiss} + {1'b0, e_both} + {1'b0, e_wbrd};
    assign err_sum = {1'b0, err_q} + {7'b0, err_inc};

    assign unused_addr = ^DDRAM_ADDR[21:MEM_AW];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (idle_wr && burst_len > 8'd1) state_nxt = WBURST;
                else if (idle_rd)                state_nxt = RLAT;
            end
            WBURST: if (wb_wr && cnt_q == 8'd1) state_nxt = IDLE;
            RLAT:   if (lat_q == 4'd0)          state_nxt = RBURST;
            RBURST: if (cnt_q == 8'd1)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DDRAM_BUSY       = rst || busy_int;
        DDRAM_DOUT_READY = ready_q && !rst;
        DDRAM_DOUT       = rst ? 64'd0 : dout_q;
        err_cnt          = err_q;
        state_dbg        = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= 8'd0;
            lat_q   <= 4'd0;
            miss_q  <= 1'b0;
            lfsr_q  <= 16'hACE1;
            dout_q  <= 64'd0;
            ready_q <= 1'b0;
            err_q   <= 8'd0;
        end else begin
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            err_q   <= err_sum[8] ? 8'hFF : err_sum[7:0];
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_wr) begin
                        addr_q <= DDRAM_ADDR[MEM_AW-1:0] + 1'b1;
                        cnt_q  <= burst_len - 8'd1;
                        miss_q <= !hit;
                    end else if (idle_rd) begin
                        addr_q <= DDRAM_ADDR[MEM_AW-1:0];
                        cnt_q  <= burst_len;
                        lat_q  <= 4'(RD_LAT - 1);
                        miss_q <= !hit;
                    end
                end
                WBURST: begin
                    if (wb_wr) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 8'd1;
                    end
                end
                RLAT: if (lat_q != 4'd0) lat_q <= lat_q - 4'd1;
                RBURST: begin
                    ready_q <= 1'b1;
                    dout_q  <= miss_q ? 64'hDEADBEEF_DEADBEEF : mem[addr_q];
                    addr_q  <= addr_q + 1'b1;
                    cnt_q   <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Store contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (mem_we && DDRAM_BE[b]) mem[mem_wa][b*8 +: 8] <= DDRAM_DIN[b*8 +: 8];
        end
    end

endmodule

// File: tb/tb_ddram_responder.sv
// Bench for ddram_responder: directed vector table, burst/reset corner sequences on a
// non-stalling instance, and a randomised write/read pass on a stalling instance.
module tb_ddram_responder;

    localparam int         RD_LAT  = 4;
    localparam int         N       = 4096;
    localparam logic [6:0] TB_BASE = 7'b0011000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        busy0, rd0, we0, rdy0;
    logic [7:0]  bc0, be0, err0;
    logic [28:0] addr0;
    logic [63:0] din0, dout0;
    logic [1:0]  st0;

    logic        busy1, rd1, we1, rdy1;
    logic [7:0]  bc1, be1, err1;
    logic [28:0] addr1;
    logic [63:0] din1, dout1;
    logic [1:0]  st1;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [63:0] exp_q[$];
    logic [63:0] wq[$];

    typedef struct {
        bit          is_wr;
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
        logic [63:0] exp_dout;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t tbl[15];

    ddram_responder #(.MEM_AW(12), .RD_LAT(RD_LAT), .STALL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .DDRAM_BUSY(busy0), .DDRAM_BURSTCNT(bc0), .DDRAM_ADDR(addr0),
        .DDRAM_RD(rd0), .DDRAM_WE(we0), .DDRAM_DIN(din0), .DDRAM_BE(be0),
        .DDRAM_DOUT(dout0), .DDRAM_DOUT_READY(rdy0), .err_cnt(err0), .state_dbg(st0)
    );

    ddram_responder #(.MEM_AW(12), .RD_LAT(RD_LAT), .STALL_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .DDRAM_BUSY(busy1), .DDRAM_BURSTCNT(bc1), .DDRAM_ADDR(addr1),
        .DDRAM_RD(rd1), .DDRAM_WE(we1), .DDRAM_DIN(din1), .DDRAM_BE(be1),
        .DDRAM_DOUT(dout1), .DDRAM_DOUT_READY(rdy1), .err_cnt(err1), .state_dbg(st1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [28:0] win(input int w);
        return {TB_BASE, 22'(w)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers for dut0 ----------------
    task automatic wr(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be,
                      input logic [7:0] bc);
        we0 = 1'b1; rd0 = 1'b0; addr0 = a; din0 = d; be0 = be; bc0 = bc;
        step();
        we0 = 1'b0;
    endtask

    // Data comes from wq; later beats drive a bogus address to show it is not resampled.
    task automatic wr_burst(input logic [28:0] a, input int n, input bit rd_on_last);
        for (int i = 0; i < n; i++) begin
            we0   = 1'b1;
            rd0   = rd_on_last && (i == n - 1);
            addr0 = (i == 0) ? a : 29'h0;
            bc0   = (i == 0) ? 8'(n) : 8'h0;
            din0  = wq[i];
            be0   = 8'hFF;
            if (i > 0) chk("wb_busy", {63'd0, busy0}, 64'd0);
            step();
        end
        we0 = 1'b0; rd0 = 1'b0;
        chk("wb_end_state", {62'd0, st0}, 64'd0);
        wq.delete();
    endtask

    // Expects exactly n beats, RD_LAT+1 cycles after accept, data popped from exp_q.
    task automatic rd_burst(input logic [28:0] a, input logic [7:0] bc, input int n);
        logic [63:0] last;
        last = 64'd0;
        rd0 = 1'b1; we0 = 1'b0; addr0 = a; bc0 = bc;
        chk("rd_accept_busy", {63'd0, busy0}, 64'd0);
        step();
        rd0 = 1'b0;
        for (int j = 1; j <= RD_LAT + n + 1; j++) begin
            step();
            if (j < RD_LAT + n) chk("rd_busy", {63'd0, busy0}, 64'd1);
            if (j >= RD_LAT + 1 && j <= RD_LAT + n) begin
                chk("rd_ready", {63'd0, rdy0}, 64'd1);
                last = exp_q.pop_front();
                chk("rd_data", dout0, last);
            end else begin
                chk("rd_ready_idle", {63'd0, rdy0}, 64'd0);
            end
            if (j == RD_LAT + n + 1) chk("dout_hold", dout0, last);
        end
    endtask

    // ---------------- drivers for dut1 (honour BUSY) ----------------
    task automatic wr1(input logic [28:0] a, input logic [63:0] d);
        bit done;
        done = 1'b0;
        we1 = 1'b1; rd1 = 1'b0; addr1 = a; din1 = d; be1 = 8'hFF; bc1 = 8'd1;
        for (int t = 0; t < 64 && !done; t++) begin
            done = (busy1 == 1'b0);
            step();
        end
        we1 = 1'b0;
        chk("wr1_accept", {63'd0, done}, 64'd1);
    endtask

    task automatic rd1_chk(input logic [28:0] a, input logic [63:0] exp);
        bit done, got;
        logic [63:0] d;
        done = 1'b0; got = 1'b0; d = 64'd0;
        rd1 = 1'b1; we1 = 1'b0; addr1 = a; bc1 = 8'd1;
        for (int t = 0; t < 64 && !done; t++) begin
            done = (busy1 == 1'b0);
            step();
        end
        rd1 = 1'b0;
        chk("rd1_accept", {63'd0, done}, 64'd1);
        for (int t = 0; t < 32 && !got; t++) begin
            step();
            if (rdy1) begin
                got = 1'b1;
                d   = dout1;
            end
        end
        chk("rd1_ready", {63'd0, got}, 64'd1);
        if (got) chk("rd1_data", d, exp);
    endtask

    // ---------------- scoreboard model for the random pass ----------------
    logic [63:0] model1 [N];
    int          waddr_q[$];

    initial begin
        logic [15:0] m;
        logic [63:0] rd_exp;
        int          a;

        rd0 = 0; we0 = 0; bc0 = 0; be0 = 0; addr0 = 0; din0 = 0;
        rd1 = 0; we1 = 0; bc1 = 0; be1 = 0; addr1 = 0; din1 = 0;

        tbl[0]  = '{1'b1, win(16'h10), 64'h0123456789ABCDEF, 8'hFF, 64'h0, 8'd0};
        tbl[1]  = '{1'b0, win(16'h10), 64'h0, 8'h00, 64'h0123456789ABCDEF, 8'd0};
        tbl[2]  = '{1'b1, win(16'h20), 64'h1111111111111111, 8'hFF, 64'h0, 8'd0};
        tbl[3]  = '{1'b1, win(16'h20), 64'h2222222222222222, 8'hF0, 64'h0, 8'd0};
        tbl[4]  = '{1'b0, win(16'h20), 64'h0, 8'h00, 64'h2222222211111111, 8'd0};
        tbl[5]  = '{1'b1, win(5), 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 64'h0, 8'd0};
        tbl[6]  = '{1'b1, 29'h0000005, 64'hCAFEBABE_CAFEBABE, 8'hFF, 64'h0, 8'd1};
        tbl[7]  = '{1'b0, 29'h0000005, 64'h0, 8'h00, 64'hDEADBEEF_DEADBEEF, 8'd2};
        tbl[8]  = '{1'b0, win(5), 64'h0, 8'h00, 64'hA5A5A5A5_5A5A5A5A, 8'd2};
        tbl[9]  = '{1'b1, win(16'h30), 64'h0, 8'hFF, 64'h0, 8'd2};
        tbl[10] = '{1'b1, win(16'h30), 64'hAABBCCDD_EEFF0011, 8'h81, 64'h0, 8'd2};
        tbl[11] = '{1'b0, win(16'h30), 64'h0, 8'h00, 64'hAA000000_00000011, 8'd2};
        tbl[12] = '{1'b1, {7'b0011001, 22'h5}, 64'h1234, 8'hFF, 64'h0, 8'd3};
        tbl[13] = '{1'b0, win(5), 64'h0, 8'h00, 64'hA5A5A5A5_5A5A5A5A, 8'd3};
        tbl[14] = '{1'b0, {7'b1111111, 22'h30}, 64'h0, 8'h00, 64'hDEADBEEF_DEADBEEF, 8'd4};

        // reset state
        step(); step();
        chk("rst_busy0", {63'd0, busy0}, 64'd1);
        chk("rst_ready0", {63'd0, rdy0}, 64'd0);
        chk("rst_dout0", dout0, 64'd0);
        chk("rst_err0", {56'd0, err0}, 64'd0);
        chk("rst_state0", {62'd0, st0}, 64'd0);
        chk("rst_busy1", {63'd0, busy1}, 64'd1);
        rst = 1'b0;
        #1;
        chk("post_rst_busy0", {63'd0, busy0}, 64'd0);

        // directed vector table
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].addr, tbl[i].din, tbl[i].be, 8'd1);
            end else begin
                exp_q.push_back(tbl[i].exp_dout);
                rd_burst(tbl[i].addr, 8'd1, 1);
            end
            chk("tbl_err", {56'd0, err0}, {56'd0, tbl[i].exp_err});
        end

        // write and read bursts that wrap the top of the store
        wq = '{64'(N - 2), 64'(N - 1), 64'd0, 64'd1};
        wr_burst(win(N - 2), 4, 1'b0);
        exp_q = '{64'(N - 2), 64'(N - 1), 64'd0, 64'd1};
        rd_burst(win(N - 2), 8'd4, 4);

        // RD during a write burst is ignored but counted
        wq = '{64'h5050_0000_0000_0001, 64'h5050_0000_0000_0002};
        wr_burst(win(16'h50), 2, 1'b1);
        chk("wb_rd_err", {56'd0, err0}, 64'd5);
        exp_q = '{64'h5050_0000_0000_0001, 64'h5050_0000_0000_0002};
        rd_burst(win(16'h50), 8'd2, 2);

        // simultaneous RD and WE in IDLE: write only, counted
        we0 = 1'b1; rd0 = 1'b1; addr0 = win(16'h60); din0 = 64'h6060_6060_6060_6060;
        be0 = 8'hFF; bc0 = 8'd1;
        step();
        we0 = 1'b0; rd0 = 1'b0;
        chk("both_state", {62'd0, st0}, 64'd0);
        chk("both_err", {56'd0, err0}, 64'd6);
        step();
        chk("both_noready", {63'd0, rdy0}, 64'd0);
        exp_q.push_back(64'h6060_6060_6060_6060);
        rd_burst(win(16'h60), 8'd1, 1);

        // BURSTCNT of zero behaves as one beat
        wr(win(16'h70), 64'h7777_0000_0000_7777, 8'hFF, 8'd0);
        chk("bc0_state", {62'd0, st0}, 64'd0);
        exp_q.push_back(64'h7777_0000_0000_7777);
        rd_burst(win(16'h70), 8'd0, 1);

        // err_cnt saturation
        for (int i = 1; i <= 260; i++) begin
            wr(29'h0000005, 64'h0, 8'hFF, 8'd1);
            if (i == 248) chk("err_fe", {56'd0, err0}, 64'hFE);
        end
        chk("err_sat", {56'd0, err0}, 64'hFF);

        // reset on the second beat of a 4-beat read
        wq = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
        wr_burst(win(16'h40), 4, 1'b0);
        rd0 = 1'b1; addr0 = win(16'h40); bc0 = 8'd4;
        step();
        rd0 = 1'b0;
        repeat (RD_LAT + 1) step();
        chk("mid_beat0_rdy", {63'd0, rdy0}, 64'd1);
        chk("mid_beat0", dout0, 64'hA0);
        step();
        chk("mid_beat1", dout0, 64'hA1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", {63'd0, rdy0}, 64'd0);
        chk("mid_rst_dout", dout0, 64'd0);
        chk("mid_rst_busy", {63'd0, busy0}, 64'd1);
        step();
        chk("mid_rst_rdy2", {63'd0, rdy0}, 64'd0);
        chk("mid_rst_state", {62'd0, st0}, 64'd0);
        chk("mid_rst_err", {56'd0, err0}, 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_rdy", {63'd0, rdy0}, 64'd0);
        end
        exp_q = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
        rd_burst(win(16'h40), 8'd4, 4);

        // stalling instance: BUSY pattern right after reset
        rst = 1'b1;
        step(); step();
        chk("rst1_busy", {63'd0, busy1}, 64'd1);
        rst = 1'b0;
        #1;
        m = 16'hACE1;
        for (int i = 0; i < 40; i++) begin
            chk("lfsr_busy", {63'd0, busy1}, {63'd0, (m[1:0] == 2'b00)});
            step();
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end

        // random single writes then reads, master honouring BUSY
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, N - 1));
            model1[a] = {$urandom, $urandom};
            waddr_q.push_back(a);
            wr1(win(a), model1[a]);
        end
        while (waddr_q.size() > 0) begin
            a = waddr_q.pop_front();
            rd_exp = model1[a];
            rd1_chk(win(a), rd_exp);
        end
        chk("stall_err", {56'd0, err1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
